// File: rtl/reg_issue_if.sv
// Bundle for the operand-issue stage: upstream instruction handshake, execute slot,
// write-back port and debug read port.
interface reg_issue_if #(
    parameter int DATA_WIDTH = 32,
    parameter int INST_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  inst_valid_i;
    logic [INST_WIDTH-1:0] inst_i;
    logic                  inst_ready_o;
    logic                  exe_valid_o;
    logic                  exe_ready_i;
    logic [DATA_WIDTH-1:0] op1_o;
    logic [DATA_WIDTH-1:0] op2_o;
    logic [INST_WIDTH-1:0] inst_o;
    logic [ADDR_WIDTH-1:0] reg_waddr_o;
    logic                  wb_we_i;
    logic [ADDR_WIDTH-1:0] wb_waddr_i;
    logic [DATA_WIDTH-1:0] wb_wdata_i;
    logic [ADDR_WIDTH-1:0] dbg_raddr_i;
    logic [DATA_WIDTH-1:0] dbg_rdata_o;

    modport master (
        output inst_valid_i, inst_i, exe_ready_i, wb_we_i, wb_waddr_i, wb_wdata_i, dbg_raddr_i,
        input  inst_ready_o, exe_valid_o, op1_o, op2_o, inst_o, reg_waddr_o, dbg_rdata_o
    );

    modport slave (
        input  inst_valid_i, inst_i, exe_ready_i, wb_we_i, wb_waddr_i, wb_wdata_i, dbg_raddr_i,
        output inst_ready_o, exe_valid_o, op1_o, op2_o, inst_o, reg_waddr_o, dbg_rdata_o
    );
endinterface

// File: rtl/reg_issue.sv
// Operand-issue stage: register file with write-back bypass, immediate formation,
// per-register scoreboard for RAW/WAW stalls, and a one-entry registered execute slot.
module reg_issue #(
    parameter int DATA_WIDTH = 32,
    parameter int INST_WIDTH = 32,
    parameter int REG_NUM    = 32,
    parameter int ADDR_WIDTH = 5
) (
    input logic        clk_i,
    input logic        rst_i,
    reg_issue_if.slave bus
);
    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_IMM = 7'b0010011;

    logic [DATA_WIDTH-1:0] regs [REG_NUM];
    logic [REG_NUM-1:0]    sb;
    logic [REG_NUM-1:0]    sb_next;

    logic                  exe_valid_q;
    logic [DATA_WIDTH-1:0] op1_q;
    logic [DATA_WIDTH-1:0] op2_q;
    logic [INST_WIDTH-1:0] inst_q;
    logic [ADDR_WIDTH-1:0] rd_q;

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [ADDR_WIDTH-1:0] rs1;
    logic [ADDR_WIDTH-1:0] rs2;
    logic [ADDR_WIDTH-1:0] rd;
    logic                  is_r;
    logic                  is_imm;
    logic                  writes_rd;
    logic                  bypass1;
    logic                  bypass2;
    logic                  wb_hits_rd;
    logic [DATA_WIDTH-1:0] rs1_val;
    logic [DATA_WIDTH-1:0] rs2_val;
    logic [DATA_WIDTH-1:0] op1_d;
    logic [DATA_WIDTH-1:0] op2_d;
    logic                  stall;
    logic                  slot_free;
    logic                  inst_ready;
    logic                  issue;
    logic                  wb_write;

    assign opcode    = bus.inst_i[6:0];
    assign funct3    = bus.inst_i[14:12];
    assign rd        = bus.inst_i[11:7];
    assign rs1       = bus.inst_i[19:15];
    assign rs2       = bus.inst_i[24:20];
    assign is_r      = (opcode == OPC_R);
    assign is_imm    = (opcode == OPC_IMM);
    assign writes_rd = is_r || is_imm;

    assign wb_write   = bus.wb_we_i && (bus.wb_waddr_i != '0);
    assign bypass1    = bus.wb_we_i && (bus.wb_waddr_i == rs1) && (rs1 != '0);
    assign bypass2    = bus.wb_we_i && (bus.wb_waddr_i == rs2) && (rs2 != '0);
    assign wb_hits_rd = bus.wb_we_i && (bus.wb_waddr_i == rd);

    // Operand read: x0 is hardwired to zero, otherwise same-cycle write-back wins over the file.
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1 != '0) rs1_val = bypass1 ? bus.wb_wdata_i : regs[rs1];
        if (rs2 != '0) rs2_val = bypass2 ? bus.wb_wdata_i : regs[rs2];
    end

    always_comb begin
        op1_d = '0;
        op2_d = '0;
        if (is_r) begin
            op1_d = rs1_val;
            op2_d = rs2_val;
        end else if (is_imm) begin
            op1_d = rs1_val;
            // Shift-immediates carry an unsigned shamt; everything else is a signed 12-bit imm.
            if (funct3 == 3'b001 || funct3 == 3'b101)
                op2_d = {{(DATA_WIDTH-5){1'b0}}, bus.inst_i[24:20]};
            else
                op2_d = {{(DATA_WIDTH-12){bus.inst_i[31]}}, bus.inst_i[31:20]};
        end
    end

    always_comb begin
        stall = 1'b0;
        if (writes_rd && sb[rs1] && !bypass1) stall = 1'b1;
        if (is_r && sb[rs2] && !bypass2) stall = 1'b1;
        if (writes_rd && (rd != '0) && sb[rd] && !wb_hits_rd) stall = 1'b1;
    end

    // Handshake: a transfer happens on a cycle where valid && ready are both high. inst_ready_o
    // never depends on inst_valid_i; the slot holds its contents while exe_valid_o && !exe_ready_i.
    assign slot_free  = !exe_valid_q || bus.exe_ready_i;
    assign inst_ready = !rst_i && !stall && slot_free;
    assign issue      = bus.inst_valid_i && inst_ready;

    // Clear from write-back first, then set from issue, so a same-index set wins.
    always_comb begin
        sb_next = sb;
        if (wb_write) sb_next[bus.wb_waddr_i] = 1'b0;
        if (issue && writes_rd && (rd != '0)) sb_next[rd] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
        end else if (wb_write) begin
            regs[bus.wb_waddr_i] <= bus.wb_wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sb          <= '0;
            exe_valid_q <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
            inst_q      <= '0;
            rd_q        <= '0;
        end else begin
            sb <= sb_next;
            if (issue) begin
                exe_valid_q <= 1'b1;
                op1_q       <= op1_d;
                op2_q       <= op2_d;
                inst_q      <= bus.inst_i;
                rd_q        <= rd;
            end else if (bus.exe_ready_i) begin
                exe_valid_q <= 1'b0;
            end
        end
    end

    assign bus.inst_ready_o = inst_ready;
    assign bus.exe_valid_o  = exe_valid_q;
    assign bus.op1_o        = op1_q;
    assign bus.op2_o        = op2_q;
    assign bus.inst_o       = inst_q;
    assign bus.reg_waddr_o  = rd_q;
    assign bus.dbg_rdata_o  = regs[bus.dbg_raddr_i];
endmodule

// File: tb/tb_reg_issue.sv
// Bench for reg_issue: directed steps from the test plan, then randomized traffic, all checked
// against a behavioural register/busy-bit model and an expected queue of issued instructions.
module tb_reg_issue;
  localparam int DW = 32;
  localparam int IW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_issue_if #(.DATA_WIDTH(DW), .INST_WIDTH(IW), .ADDR_WIDTH(AW)) bus ();

  reg_issue #(.DATA_WIDTH(DW), .INST_WIDTH(IW), .REG_NUM(32), .ADDR_WIDTH(AW)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [32];
  bit          m_busy [32];
  bit          m_valid;
  logic [31:0] m_op1, m_op2, m_inst;
  logic [4:0]  m_rd;
  logic [31:0] exp_q [$];
  logic        last_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_valid = 1'b0;
    m_op1 = '0; m_op2 = '0; m_inst = '0; m_rd = '0;
    exp_q.delete();
  endtask

  // A source/destination is blocked while its producer is outstanding, unless it retires now.
  function automatic bit blocked(input logic [4:0] r);
    return (r != 5'd0) && m_busy[r] && !(bus.wb_we_i && bus.wb_waddr_i == r);
  endfunction

  function automatic logic [31:0] read_val(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (bus.wb_we_i && bus.wb_waddr_i == r) return bus.wb_wdata_i;
    return m_regs[r];
  endfunction

  task automatic drive(input bit v, input logic [31:0] ins, input bit er,
                       input bit we, input logic [4:0] wa, input logic [31:0] wd);
    bus.inst_valid_i = v;
    bus.inst_i       = ins;
    bus.exe_ready_i  = er;
    bus.wb_we_i      = we;
    bus.wb_waddr_i   = wa;
    bus.wb_wdata_i   = wd;
  endtask

  // One clock: check combinational outputs mid-cycle, advance the model, check the slot after the edge.
  task automatic tick();
    logic [31:0] ins;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    bit          is_r, is_i, rdy, fire;
    @(negedge clk);
    ins  = bus.inst_i;
    is_r = (ins[6:0] == 7'b0110011);
    is_i = (ins[6:0] == 7'b0010011);
    rs1  = ins[19:15];
    rs2  = ins[24:20];
    rd   = ins[11:7];
    f3   = ins[14:12];
    rdy  = !rst && (!m_valid || bus.exe_ready_i);
    if (is_r || is_i) begin
      if (blocked(rs1)) rdy = 1'b0;
      if (is_r && blocked(rs2)) rdy = 1'b0;
      if (blocked(rd)) rdy = 1'b0;
    end
    last_ready = bus.inst_ready_o;
    chk("inst_ready", bus.inst_ready_o, rdy);
    fire = bus.inst_valid_i && rdy;
    if (rst) begin
      model_clear();
    end else begin
      chk("dbg_rdata", bus.dbg_rdata_o, m_regs[bus.dbg_raddr_i]);
      if (m_valid && bus.exe_ready_i && exp_q.size() > 0)
        chk("consumed_inst", bus.inst_o, exp_q.pop_front());
      if (fire) begin
        m_op1 = (is_r || is_i) ? read_val(rs1) : 32'd0;
        if (is_r) m_op2 = read_val(rs2);
        else if (is_i && (f3 == 3'd1 || f3 == 3'd5)) m_op2 = {27'd0, ins[24:20]};
        else if (is_i) m_op2 = {{20{ins[31]}}, ins[31:20]};
        else m_op2 = 32'd0;
        m_inst = ins;
        m_rd   = rd;
      end
      if (bus.wb_we_i && bus.wb_waddr_i != 5'd0) begin
        m_regs[bus.wb_waddr_i] = bus.wb_wdata_i;
        m_busy[bus.wb_waddr_i] = 1'b0;
      end
      if (fire) begin
        m_valid = 1'b1;
        if ((is_r || is_i) && rd != 5'd0) m_busy[rd] = 1'b1;
        exp_q.push_back(ins);
      end else if (bus.exe_ready_i) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("exe_valid", bus.exe_valid_o, m_valid);
    if (m_valid) begin
      chk("op1", bus.op1_o, m_op1);
      chk("op2", bus.op2_o, m_op2);
      chk("inst_o", bus.inst_o, m_inst);
      chk("reg_waddr", bus.reg_waddr_o, m_rd);
    end
  endtask

  initial begin
    logic [6:0]  op;
    logic [31:0] ins;
    model_clear();
    drive(1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0);
    bus.dbg_raddr_i = 5'd5;
    rst = 1'b1;

    // Reset for two cycles
    tick(); tick();
    rst = 1'b0;
    chk("reset_exe_valid", bus.exe_valid_o, 1'b0);
    chk("reset_op1", bus.op1_o, 32'd0);
    chk("reset_op2", bus.op2_o, 32'd0);
    chk("reset_inst", bus.inst_o, 32'd0);
    chk("reset_rd", bus.reg_waddr_o, 32'd0);
    chk("reset_dbg5", bus.dbg_rdata_o, 32'd0);
    tick();
    chk("reset_ready", last_ready, 1'b1);

    // R-type with preloaded operands
    drive(1'b0, 32'd0, 1'b1, 1'b1, 5'd1, 32'd5); tick();
    drive(1'b0, 32'd0, 1'b1, 1'b1, 5'd2, 32'd7); tick();
    drive(1'b1, 32'h002081B3, 1'b1, 1'b0, 5'd0, 32'd0); tick();
    chk("add_valid", bus.exe_valid_o, 1'b1);
    chk("add_op1", bus.op1_o, 32'd5);
    chk("add_op2", bus.op2_o, 32'd7);
    chk("add_rd", bus.reg_waddr_o, 32'd3);
    chk("add_inst", bus.inst_o, 32'h002081B3);

    // Immediate then RAW stall resolved by same-cycle write-back bypass
    drive(1'b1, 32'hFFF00293, 1'b1, 1'b0, 5'd0, 32'd0); tick();
    chk("addi_op1", bus.op1_o, 32'd0);
    chk("addi_op2", bus.op2_o, 32'hFFFFFFFF);
    drive(1'b1, 32'h00429313, 1'b1, 1'b0, 5'd0, 32'd0);
    tick(); chk("raw_stall_a", last_ready, 1'b0);
    tick(); chk("raw_stall_b", last_ready, 1'b0);
    drive(1'b1, 32'h00429313, 1'b1, 1'b1, 5'd5, 32'hFFFFFFFF); tick();
    chk("raw_release", last_ready, 1'b1);
    chk("slli_op1", bus.op1_o, 32'hFFFFFFFF);
    chk("slli_op2", bus.op2_o, 32'd4);

    // Backpressure: slot held for three cycles, then drained
    drive(1'b1, 32'h002083B3, 1'b1, 1'b0, 5'd0, 32'd0); tick();
    drive(1'b1, 32'h00100413, 1'b0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_ready", last_ready, 1'b0);
      chk("bp_inst", bus.inst_o, 32'h002083B3);
      chk("bp_op1", bus.op1_o, 32'd5);
      chk("bp_op2", bus.op2_o, 32'd7);
    end
    drive(1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0); tick();
    chk("bp_drain", bus.exe_valid_o, 1'b0);

    // x0 protection
    bus.dbg_raddr_i = 5'd0;
    drive(1'b1, 32'h00000093, 1'b1, 1'b1, 5'd0, 32'hDEADBEEF); tick();
    chk("x0_dbg", bus.dbg_rdata_o, 32'd0);
    chk("x0_op1", bus.op1_o, 32'd0);

    // Reset mid-flight
    drive(1'b1, 32'hFFF00293, 1'b1, 1'b0, 5'd0, 32'd0); tick();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0); tick();
    chk("mid_valid", bus.exe_valid_o, 1'b1);
    rst = 1'b1; tick();
    rst = 1'b0;
    chk("mid_dropped", bus.exe_valid_o, 1'b0);
    drive(1'b1, 32'h00429313, 1'b1, 1'b0, 5'd0, 32'd0); tick();
    chk("mid_accept", last_ready, 1'b1);
    chk("mid_op1", bus.op1_o, 32'd0);
    chk("mid_op2", bus.op2_o, 32'd4);

    // Randomized traffic over a small register window to provoke hazards
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 149) == 0);
      case ($urandom_range(0, 2))
        0: op = 7'b0110011;
        1: op = 7'b0010011;
        default: begin
          op = 7'($urandom_range(0, 127));
          if (op == 7'b0110011 || op == 7'b0010011) op = 7'b1100011;
        end
      endcase
      ins = {7'($urandom_range(0, 127)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), op};
      drive(1'($urandom_range(0, 1)), ins, ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      bus.dbg_raddr_i = 5'($urandom_range(0, 7));
      tick();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
